// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit.
package mips_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_ITER = 32;

    // Magnitude of an operand; unsigned ops pass the value through untouched.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        mag32 = (is_signed && v[31]) ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers.
// Multiply: shift-add on a 64-bit accumulator. Divide: restoring, one quotient bit per cycle.
module muldiv_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_e,
    input  logic [1:0]  op_e,
    input  logic [31:0] a_e,
    input  logic [31:0] b_e,
    input  logic        flush_e,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state;
    logic [4:0]  count;
    md_op_e      op;
    logic [31:0] a_raw;    // original dividend, returned in hi on divide-by-zero
    logic [31:0] opnd_b;   // multiplicand / divisor magnitude
    logic [63:0] acc;      // mult: {partial product, multiplier}; div: low half holds dividend->quotient
    logic [31:0] rem;      // divide partial remainder
    logic        neg_q;    // negate product / quotient at completion
    logic        neg_r;    // negate remainder at completion

    logic [32:0] mul_sum;
    logic [32:0] shifted;
    logic        ge;
    logic [63:0] acc_nxt;
    logic [31:0] rem_nxt;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        is_signed;

    assign busy      = (state == RUN);
    assign stall_md  = busy & md_use_d;
    assign is_signed = ~op_e[0];

    // One iteration step for whichever operation is in flight.
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
        shifted = {rem, acc[31]};
        ge      = (shifted >= {1'b0, opnd_b});
        acc_nxt = acc;
        rem_nxt = rem;
        if (op == MULT || op == MULTU) begin
            acc_nxt = {mul_sum, acc[31:1]};
        end else begin
            // Restored remainder always fits 32 bits, so the low-half subtract is exact.
            acc_nxt = {acc[63:32], acc[30:0], ge};
            rem_nxt = shifted[31:0] - (ge ? opnd_b : 32'd0);
        end
    end

    // Sign fix-up of the final step's result, including the divide-by-zero case.
    always_comb begin
        prod   = neg_q ? 64'(-acc_nxt) : acc_nxt;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (op == DIV || op == DIVU) begin
            if (opnd_b == 32'd0) begin
                res_lo = '1;
                res_hi = a_raw;
            end else begin
                res_lo = neg_q ? 32'(-acc_nxt[31:0]) : acc_nxt[31:0];
                res_hi = neg_r ? 32'(-rem_nxt) : rem_nxt;
            end
        end
    end

    // Control FSM, operand capture, iteration state and HI/LO architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            op     <= MULT;
            a_raw  <= '0;
            opnd_b <= '0;
            acc    <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_e && !flush_e) begin
                        state  <= RUN;
                        count  <= '0;
                        op     <= md_op_e'(op_e);
                        a_raw  <= a_e;
                        opnd_b <= mag32(b_e, is_signed);
                        acc    <= {32'd0, mag32(a_e, is_signed)};
                        rem    <= '0;
                        neg_q  <= is_signed & (a_e[31] ^ b_e[31]);
                        neg_r  <= is_signed & a_e[31];
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    rem <= rem_nxt;
                    if (count == 5'(MD_ITER - 1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO architectural registers, sitting in the EX stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU from EX, runs 32 cycles, and produces the stall request the hazard unit consumes, so that dependent HI/LO instructions in decode are held while it is busy. It also services MTHI/MTLO writes and provides HI/LO read data for MFHI/MFLO.

## Interface

Parameters:
- none (fixed 32-bit datapath, 32 iterations)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start_e  in  1  EX holds a mult/div instruction
- op_e  in  2  md_op_e: MULT=0, MULTU=1, DIV=2, DIVU=3
- a_e  in  32  rs operand (forwarded)
- b_e  in  32  rt operand (forwarded)
- flush_e  in  1  EX flush from hazard unit; when high, start_e is ignored
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  32  MTHI/MTLO data
- md_use_d  in  1  decode holds mult/div/MFHI/MFLO/MTHI/MTLO
- busy  out  1  iteration in progress
- stall_md  out  1  busy && md_use_d (combinational), ORed into stall_f/stall_d/flush_e by the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

## Operation

- States: IDLE, RUN. Reset puts the unit in IDLE with busy=0, hi=0, lo=0, and the iteration counter at 0.
- IDLE: start_e && !flush_e captures op, operands, and sign flags, and enters RUN with count=0.
  - Signed ops (MULT, DIV) work on operand magnitudes; result sign is fixed at completion.
- RUN, multiply: shift-add, one multiplier bit per cycle, on a 64-bit accumulator.
- RUN, divide: restoring divide, one quotient bit per cycle, 33-bit partial remainder.
- Count 31: write the final result to hi/lo, return to IDLE.
  - Multiply: hi:lo = 64-bit product, negated if signs differ.
  - Divide: lo = quotient, hi = remainder. The quotient is negated if signs differ; the remainder takes the sign of the dividend.
- Division by zero (DIV and DIVU): lo=0xFFFFFFFF, hi=a_e. Takes the full 32 cycles.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- hi_we/lo_we in IDLE: write wdata on the edge.
  - In RUN they are ignored; the hazard unit guarantees they are held via stall_md.
  - Simultaneous hi_we and start_e in IDLE: start wins, and the write is dropped.
- start_e during RUN is ignored; a bench assertion flags it.
- Asynchronous rst mid-RUN aborts the operation immediately. All outputs return to their reset values.

## Timing

- Start accepted at edge N, then busy=1 from after edge N through edge N+32.
- hi/lo are updated and busy falls at edge N+32. That is 32 RUN cycles, with results visible in cycle N+32.
- stall_md has zero latency; it is combinational from busy and md_use_d.
- hi/lo are unchanged during RUN; they hold the old values until completion.
- An MFHI in decode during the last RUN cycle is stalled; it reads the new value the following cycle.
- Back-to-back: a new start is accepted at the completion edge+1 (IDLE cycle). There is no start on the completion edge itself.

## Structure

- Shared package mips_pkg:
  - md_op_e enum
  - md_state_e {IDLE, RUN}
  - MD_ITER = 32
- Single module. No sub-module is warranted; the sign pre/post-processing is a local function.
- The hazard unit gains one input, stall_md, which is ORed into stall_all.

## Test plan

- MULTU a=0xFFFFFFFF b=0xFFFFFFFF: busy for 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3) b=5: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7) b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7 b=0: lo=0xFFFFFFFF, hi=7.
- Stall: start, then hold md_use_d=1.
  - stall_md=1 for exactly 32 cycles, and 0 in the cycle after hi/lo update.
  - MTLO 0x1234 issued in IDLE gives lo=0x1234 next cycle.
- Flush and reset:
  - start_e with flush_e=1: busy stays 0.
  - Assert rst at RUN count 10: busy=0, hi=lo=0 immediately.
  - A new start after reset completes correctly.
